// File: rtl/io_port_bridge_pkg.sv
// ============================================================================
// Module : io_port_pkg
// Brief  : Shared types and default sizes for the CPU I/O port bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package io_port_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DEPTH = 4;

   typedef enum logic [0:0] {
      RX_EMPTY = 1'b0,
      RX_FULL  = 1'b1
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/io_port_bridge_if.sv
// ============================================================================
// Module : io_port_bridge_if
// Brief  : CPU port, tx and rx valid-ready channels of the I/O port bridge.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface io_port_bridge_if
   import io_port_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic [WIDTH-1:0] cpu_out;
   logic             cpu_out_wr;
   logic [WIDTH-1:0] cpu_in;
   logic             cpu_in_ack;
   logic             cpu_in_valid;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             rx_ready;
   logic [7:0]       ovf_count;

   // slave is the bridge itself; master is the CPU/link environment around it
   modport slave (
      input  cpu_out, cpu_out_wr, cpu_in_ack, tx_ready, rx_data, rx_valid,
      output cpu_in, cpu_in_valid, tx_data, tx_valid, rx_ready, ovf_count
   );

   modport master (
      output cpu_out, cpu_out_wr, cpu_in_ack, tx_ready, rx_data, rx_valid,
      input  cpu_in, cpu_in_valid, tx_data, tx_valid, rx_ready, ovf_count
   );

endinterface

`default_nettype wire

// File: rtl/io_port_bridge_fifo.sv
// ============================================================================
// Module : io_port_fifo
// Brief  : Outgoing queue; caller guarantees push only when space, pop only when non-empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module io_port_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  wire logic             clk,
   input  wire logic             reset,
   input  wire logic             i_push,
   input  wire logic [WIDTH-1:0] i_data,
   input  wire logic             i_pop,
   output logic      [WIDTH-1:0] o_data,
   output logic                  o_full,
   output logic                  o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/io_port_bridge.sv
// ============================================================================
// Module : io_port_bridge
// Brief  : CPU out-port to tx FIFO, rx channel to one-word CPU in-port holder.
//          IO_PORT_BRIDGE_OVF_CNT_EN enables the saturating dropped-write counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module io_port_bridge
   import io_port_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  wire logic  clk,
   input  wire logic  reset,
   io_port_bridge_if.slave bus
);
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic [WIDTH-1:0] w_head;

   rx_state_t        r_state;
   rx_state_t        w_next;
   logic [WIDTH-1:0] r_cpu_in;

   // A full queue still accepts a write when its head leaves in the same cycle
   assign w_pop  = !w_empty && bus.tx_ready;
   assign w_push = bus.cpu_out_wr && (!w_full || w_pop);

   io_port_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (bus.cpu_out),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus.tx_valid = !w_empty;
   assign bus.tx_data  = w_head;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= RX_EMPTY;
         r_cpu_in <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == RX_EMPTY && bus.rx_valid) begin
            r_cpu_in <= bus.rx_data;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         RX_EMPTY: if (bus.rx_valid)   w_next = RX_FULL;
         RX_FULL:  if (bus.cpu_in_ack) w_next = RX_EMPTY;
         default:  w_next = RX_EMPTY;
      endcase
   end

   assign bus.rx_ready     = (r_state == RX_EMPTY);
   assign bus.cpu_in_valid = (r_state == RX_FULL);
   assign bus.cpu_in       = r_cpu_in;

`ifdef IO_PORT_BRIDGE_OVF_CNT_EN
   logic [7:0] r_ovf_count;
   logic       w_drop;

   assign w_drop = bus.cpu_out_wr && w_full && !w_pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ovf_count <= '0;
      end else if (w_drop && r_ovf_count != 8'hFF) begin
         r_ovf_count <= r_ovf_count + 8'd1;
      end
   end

   assign bus.ovf_count = r_ovf_count;
`else
   assign bus.ovf_count = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_port_bridge.sv
// ============================================================================
// Module : tb_io_port_bridge
// Brief  : Self-checking bench for io_port_bridge (honours IO_PORT_BRIDGE_OVF_CNT_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_io_port_bridge;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;

   logic clk;
   logic reset;

   io_port_bridge_if #(.WIDTH(WIDTH)) bus ();

   io_port_bridge #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             rv;
      logic [WIDTH-1:0] rd;
      logic             ack;
      logic [WIDTH-1:0] e_in;
      logic             e_v;
      logic             e_rdy;
   } rx_vec_t;

   int               checks;
   int               errors;
   int               drops;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] last_tx;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_ovf();
`ifdef IO_PORT_BRIDGE_OVF_CNT_EN
      return (drops > 255) ? 32'd255 : 32'(drops);
`else
      return 32'd0;
`endif
   endfunction

   // Model the queue at the falling edge, then advance to just past the next rising edge
   task automatic cycle();
      @(negedge clk);
      if (reset) begin
         chk("tx_valid", 32'(bus.tx_valid), 32'(exp_q.size() != 0));
         if (exp_q.size() != 0 && bus.tx_ready) begin
            chk("tx_data", 32'(bus.tx_data), 32'(exp_q[0]));
            last_tx = exp_q.pop_front();
         end
         if (bus.cpu_out_wr) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(bus.cpu_out);
            else drops++;
         end
      end else begin
         exp_q.delete();
         drops = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      bus.cpu_out_wr = 1'b0;
      bus.tx_ready   = 1'b1;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) cycle();
      chk("drain_done", 32'(exp_q.size()), 32'd0);
      cycle();
      chk("tx_idle", 32'(bus.tx_valid), 32'd0);
   endtask

   task automatic write(input logic [WIDTH-1:0] d);
      bus.cpu_out    = d;
      bus.cpu_out_wr = 1'b1;
      cycle();
      bus.cpu_out_wr = 1'b0;
   endtask

   rx_vec_t tbl[8];

   initial begin
      checks = 0;
      errors = 0;
      drops  = 0;
      last_tx = '0;
      tbl[0] = '{1'b1, 16'h1234, 1'b0, 16'h1234, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 16'h5678, 1'b0, 16'h1234, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 16'h5678, 1'b1, 16'h1234, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 16'h5678, 1'b0, 16'h5678, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 16'h0000, 1'b1, 16'h5678, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 16'h0000, 1'b1, 16'h5678, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 16'h0000, 1'b0, 16'h00FF, 1'b1, 1'b0};

      reset          = 1'b0;
      bus.cpu_out    = '0;
      bus.cpu_out_wr = 1'b0;
      bus.cpu_in_ack = 1'b0;
      bus.tx_ready   = 1'b0;
      bus.rx_data    = '0;
      bus.rx_valid   = 1'b0;
      cycle();
      cycle();
      chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
      chk("rst_cpu_in", 32'(bus.cpu_in), 32'd0);
      chk("rst_cpu_in_valid", 32'(bus.cpu_in_valid), 32'd0);
      chk("rst_ovf", 32'(bus.ovf_count), 32'd0);
      reset = 1'b1;
      cycle();
      chk("rst_rx_ready", 32'(bus.rx_ready), 32'd1);

      for (int i = 0; i < 8; i++) begin
         bus.rx_valid   = tbl[i].rv;
         bus.rx_data    = tbl[i].rd;
         bus.cpu_in_ack = tbl[i].ack;
         cycle();
         chk($sformatf("rx%0d_cpu_in", i), 32'(bus.cpu_in), 32'(tbl[i].e_in));
         chk($sformatf("rx%0d_valid", i), 32'(bus.cpu_in_valid), 32'(tbl[i].e_v));
         chk($sformatf("rx%0d_ready", i), 32'(bus.rx_ready), 32'(tbl[i].e_rdy));
      end
      bus.rx_valid   = 1'b0;
      bus.cpu_in_ack = 1'b0;

      // single write: visible one edge later, gone after one transfer
      bus.tx_ready = 1'b1;
      write(16'h0003);
      chk("w1_tx_valid", 32'(bus.tx_valid), 32'd1);
      chk("w1_tx_data", 32'(bus.tx_data), 32'h0003);
      cycle();
      chk("w1_tx_valid_low", 32'(bus.tx_valid), 32'd0);
      chk("w1_last_tx", 32'(last_tx), 32'h0003);

      // five writes into a 4-deep queue with no drain
      bus.tx_ready = 1'b0;
      for (int i = 1; i <= 5; i++) write(16'(i));
      cycle();
      chk("full_ovf", 32'(bus.ovf_count), exp_ovf());
      chk("full_head", 32'(bus.tx_data), 32'd1);
      chk("full_stable_valid", 32'(bus.tx_valid), 32'd1);
      drain();
      chk("full_last", 32'(last_tx), 32'd4);

      // full queue, pop and push in the same cycle
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) write(16'hB1 + 16'(i));
      bus.tx_ready = 1'b1;
      write(16'hAAAA);
      chk("pp_ovf", 32'(bus.ovf_count), exp_ovf());
      drain();
      chk("pp_last", 32'(last_tx), 32'hAAAA);

      // ovf saturation
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 264; i++) write(16'h0C00 + 16'(i));
      cycle();
      chk("sat_ovf", 32'(bus.ovf_count), exp_ovf());
      drain();
      chk("sat_last", 32'(last_tx), 32'h0C03);

      // pointer wrap, 3*DEPTH+1 streaming writes
      begin
         int d0;
         d0 = drops;
         bus.tx_ready = 1'b1;
         for (int i = 0; i < 3 * DEPTH + 1; i++) write(16'h0100 + 16'(i));
         drain();
         chk("wrap_drops", 32'(drops), 32'(d0));
         chk("wrap_last", 32'(last_tx), 32'h0100 + 32'(3 * DEPTH));
         chk("wrap_ovf", 32'(bus.ovf_count), exp_ovf());
      end

      // reset mid-transfer with words queued and cpu_in held
      bus.tx_ready = 1'b0;
      for (int i = 0; i < 3; i++) write(16'h0D00 + 16'(i));
      chk("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
      chk("pre_rst_cpu_in_valid", 32'(bus.cpu_in_valid), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("arst_cpu_in_valid", 32'(bus.cpu_in_valid), 32'd0);
      chk("arst_rx_ready", 32'(bus.rx_ready), 32'd1);
      chk("arst_ovf", 32'(bus.ovf_count), 32'd0);
      bus.tx_ready = 1'b1;
      cycle();
      cycle();
      reset = 1'b1;
      cycle();
      chk("post_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("post_rst_cpu_in_valid", 32'(bus.cpu_in_valid), 32'd0);
      chk("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
      chk("post_rst_cpu_in", 32'(bus.cpu_in), 32'd0);
      write(16'h0042);
      drain();
      chk("post_rst_last", 32'(last_tx), 32'h0042);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/io_port_bridge.md
IO_PORT_BRIDGE -- requirements
Module: io_port_bridge

Interface
REQ-001 Parameter WIDTH, default 16: data width of the CPU in/out words.
REQ-002 Parameter DEPTH, default 4 (power of two, >=2): entries in the outgoing FIFO.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 cpu_out  input  WIDTH: word the CPU writes to its out port.
REQ-006 cpu_out_wr  input  1: one-cycle strobe; cpu_out is valid this cycle.
REQ-007 cpu_in  output  WIDTH: word presented to the CPU's in port.
REQ-008 cpu_in_ack  input  1: CPU consumed cpu_in this cycle.
REQ-009 cpu_in_valid  output  1: cpu_in holds an unconsumed word.
REQ-010 tx_data / tx_valid / tx_ready  output WIDTH / output 1 / input 1: external outgoing valid-ready channel.
REQ-011 rx_data / rx_valid / rx_ready  input WIDTH / input 1 / output 1: external incoming valid-ready channel.
REQ-012 ovf_count  output  8: count of CPU writes dropped because the FIFO was full.

Function
REQ-013 Outgoing FIFO SHALL enqueue cpu_out on cpu_out_wr when not full; tx_valid = FIFO not empty; tx_data = head entry.
REQ-014 A transfer SHALL occur when tx_valid && tx_ready; head pops that edge.
REQ-015 Write-to-tx_valid latency SHALL be one cycle (word enqueued at edge N is visible after edge N).
REQ-016 Simultaneous push and pop with FIFO full SHALL be accepted (count unchanged, no drop); with FIFO empty, the push SHALL NOT bypass (tx_valid rises next cycle).
REQ-017 Push when full without a pop SHALL drop the word and leave FIFO contents unchanged.
REQ-018 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; fullness is tracked with a count of log2(DEPTH)+1 bits.
REQ-019 tx_data and tx_valid SHALL remain stable while tx_valid && !tx_ready.
REQ-020 Incoming side SHALL be a two-state FSM: EMPTY (rx_ready=1, cpu_in_valid=0) and FULL (rx_ready=0, cpu_in_valid=1).
REQ-021 EMPTY->FULL on rx_valid, latching rx_data into cpu_in; FULL->EMPTY on cpu_in_ack.
REQ-022 cpu_in SHALL hold its last latched value in EMPTY (not cleared).
REQ-023 cpu_in_ack while EMPTY SHALL be ignored.
REQ-024 rx_ready SHALL be a registered function of FSM state only; an rx_valid and a cpu_in_ack in the same FULL cycle SHALL NOT accept a new word that edge.

Reset
REQ-025 While reset is low: FIFO empty, pointers 0, tx_valid=0, tx_data=0, FSM=EMPTY, rx_ready=1 from the first cycle after deassertion, cpu_in=0, cpu_in_valid=0, ovf_count=0.
REQ-026 Reset asserted mid-transfer SHALL discard all queued and held words immediately, with no further handshakes.

Configuration
REQ-027 Macro IO_PORT_BRIDGE_OVF_CNT_EN defined: ovf_count increments by one per dropped write and saturates at 255.
REQ-028 Macro IO_PORT_BRIDGE_OVF_CNT_EN undefined: no counter logic; ovf_count tied to 0.

Structure
REQ-029 Shared package io_port_pkg SHALL hold the incoming-FSM state enum (RX_EMPTY, RX_FULL) and the default WIDTH/DEPTH constants.
REQ-030 The outgoing queue SHALL be a sub-module io_port_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-031 Reset release, then single write 16'h0003 with tx_ready=1 -> tx_valid high one cycle later with tx_data=16'h0003, then low.
REQ-032 tx_ready=0, five writes 1..5 with DEPTH=4 -> FIFO holds 1..4, word 5 dropped, ovf_count=1 (macro on) or 0 (macro off); releasing tx_ready drains 1,2,3,4 in order.
REQ-033 FIFO full with tx_ready=1 and write 16'hAAAA in the same cycle -> no drop, 16'hAAAA emitted last.
REQ-034 rx_valid with rx_data=16'h1234 -> cpu_in=16'h1234, cpu_in_valid=1, rx_ready=0; second word 16'h5678 held off until cpu_in_ack, then accepted.
REQ-035 Pointer wrap: with tx_ready=1, 3*DEPTH+1 sequential writes -> all words emitted in order, none dropped.
REQ-036 reset pulled low with 3 words queued and cpu_in_valid=1 -> tx_valid=0, cpu_in_valid=0, rx_ready=1 immediately after release.
